// File: rtl/fp_vec_result_serializer.sv
// FP vector result serializer: buffers 4-lane adder results and streams
// them out lane by lane, tracking issue credit for the adder upstream.
module fp_vec_result_serializer #(
  parameter int EXP_BITS  = 5,
  parameter int MANT_BITS = 6,
  parameter int DEPTH     = 4,
  localparam int W        = EXP_BITS + MANT_BITS + 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_in,
  output logic          issue_ok,
  input  logic          in_valid,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  input  logic [W-1:0]  c_in,
  input  logic [W-1:0]  d_in,
  output logic [W-1:0]  out_data,
  output logic [1:0]    out_lane,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef logic [W-1:0] word_t;
  typedef word_t [3:0]  vec_t;

  vec_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [1:0]    lane_idx_q, lane_idx_d;
  logic          err_q, err_d;

  logic          xfer;
  logic          pop;
  logic          push;
  logic          drop;
  logic [CW:0]   load;
  vec_t          head;

  assign head = mem_q[rd_ptr_q];
  assign load = {1'b0, count_q} + {1'b0, inflight_q};

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? head[lane_idx_q] : '0;
  assign out_lane  = lane_idx_q;
  assign out_last  = out_valid & (lane_idx_q == 2'd3);
  assign count     = count_q;
  assign err       = err_q;
  assign issue_ok  = load < {1'b0, FULL};

  assign xfer = out_valid & out_ready;
  assign pop  = xfer & (lane_idx_q == 2'd3);
  assign push = in_valid & ((count_q != FULL) | pop);
  assign drop = in_valid & ~push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lane_idx_d = lane_idx_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (xfer) lane_idx_d = lane_idx_q + 2'd1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // simultaneous issue and arrival cancel out
    unique case ({issue_in, in_valid})
      2'b10: begin
        if (inflight_q != FULL)
          inflight_d = inflight_q + CW'(1);
      end
      2'b01: begin
        if (inflight_q != '0)
          inflight_d = inflight_q - CW'(1);
      end
      default: inflight_d = inflight_q;
    endcase

    if (drop)
      err_d = 1'b1;
    if (issue_in & ~issue_ok)
      err_d = 1'b1;
    if (in_valid & ~issue_in & (inflight_q == '0))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      lane_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      lane_idx_q <= lane_idx_d;
      err_q      <= err_d;
    end
  end

  // vector storage carries no reset; out_data is gated by out_valid
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {d_in, c_in, b_in, a_in};
  end

endmodule
